// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing defaults, derived-total helpers and receiver state encoding
package vga_timing_pkg;

    localparam int H_VIS_DEF = 800;
    localparam int H_FP_DEF  = 56;
    localparam int H_SW_DEF  = 120;
    localparam int H_BP_DEF  = 64;
    localparam int V_VIS_DEF = 600;
    localparam int V_FP_DEF  = 37;
    localparam int V_SW_DEF  = 6;
    localparam int V_BP_DEF  = 23;

    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        ALIGN  = 2'd1,
        LOCK   = 2'd2
    } rx_state_e;

    // Period in clocks (or lines) of one axis, counted from the sync leading edge.
    function automatic int timing_total(input int vis, input int fp, input int sw, input int bp);
        return vis + fp + sw + bp;
    endfunction

    // Offset of the first visible pixel (or line) after the sync leading edge.
    function automatic int window_start(input int sw, input int bp);
        return sw + bp;
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// rtl/sync_edge_detect.sv - registers one sync input and flags its leading (inactive-to-active) edge
module sync_edge_detect #(
    parameter logic SYNC_POL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sync_i,
    output logic edge_o
);

    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= ~SYNC_POL;
            prev_q <= ~SYNC_POL;
        end else begin
            sync_q <= sync_i;
            prev_q <= sync_q;
        end
    end

    assign edge_o = (sync_q == SYNC_POL) && (prev_q != SYNC_POL);

endmodule

// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - recovers pixel position and visible area from H/V sync and tracks timing lock
module vga_sync_receiver
    import vga_timing_pkg::*;
#(
    parameter int H_VIS    = H_VIS_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SW     = H_SW_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_VIS    = V_VIS_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SW     = V_SW_DEF,
    parameter int V_BP     = V_BP_DEF,
    parameter bit SYNC_POL = 1'b1
) (
    input  logic        CLOCK_50,
    input  logic        Reset,
    input  logic        H_SYNC,
    input  logic        V_SYNC,
    input  logic        R,
    input  logic        G,
    input  logic        B,
    output logic [10:0] RX_COLUMN,
    output logic [9:0]  RX_ROW,
    output logic        RX_DISP_ENABLE,
    output logic        RX_R,
    output logic        RX_G,
    output logic        RX_B,
    output logic        LOCKED,
    output logic        SYNC_ERR,
    output logic [7:0]  ERR_COUNT,
    output logic        FRAME_DONE
);

    localparam int H_TOTAL = timing_total(H_VIS, H_FP, H_SW, H_BP);
    localparam int V_TOTAL = timing_total(V_VIS, V_FP, V_SW, V_BP);
    localparam int H_START = window_start(H_SW, H_BP);
    localparam int V_START = window_start(V_SW, V_BP);

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_LO   = 11'(H_START);
    localparam logic [10:0] H_HI   = 11'(H_START + H_VIS);
    localparam logic [9:0]  V_LO   = 10'(V_START);
    localparam logic [9:0]  V_HI   = 10'(V_START + V_VIS);

    logic h_edge;
    logic v_edge;

    sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_h_edge (
        .clk_i (CLOCK_50),
        .rst_i (Reset),
        .sync_i(H_SYNC),
        .edge_o(h_edge)
    );

    sync_edge_detect #(.SYNC_POL(SYNC_POL)) u_v_edge (
        .clk_i (CLOCK_50),
        .rst_i (Reset),
        .sync_i(V_SYNC),
        .edge_o(v_edge)
    );

    rx_state_e   state_q;
    logic        locked_q;
    logic        sync_err_q;
    logic [7:0]  err_cnt_q;
    logic        frame_done_q;
    logic [10:0] hcnt_q, hcnt_d;
    logic [9:0]  vcnt_q, vcnt_d;
    logic [2:0]  rgb1_q, rgb2_q, rgb_q, rgb_d;
    logic [10:0] col_q, col_d;
    logic [9:0]  row_q, row_d;
    logic        de_q, de_d;

    logic line_ok, frame_ok, hcnt_sat;

    // At a leading edge the counter still holds the previous period minus one.
    assign line_ok  = (hcnt_q == H_LAST);
    assign frame_ok = (vcnt_q == V_LAST);
    assign hcnt_sat = (hcnt_q == 11'h7FF);

    always_comb begin
        hcnt_d = hcnt_q;
        vcnt_d = vcnt_q;
        if (h_edge) begin
            hcnt_d = '0;
        end else if (!hcnt_sat) begin
            hcnt_d = hcnt_q + 11'd1;
        end
        if (v_edge) begin
            vcnt_d = '0;
        end else if (h_edge && (vcnt_q != 10'h3FF)) begin
            vcnt_d = vcnt_q + 10'd1;
        end

        de_d  = locked_q && (hcnt_q >= H_LO) && (hcnt_q < H_HI)
                         && (vcnt_q >= V_LO) && (vcnt_q < V_HI);
        col_d = de_d ? (hcnt_q - H_LO) : '0;
        row_d = de_d ? (vcnt_q - V_LO) : '0;
        rgb_d = de_d ? rgb2_q : '0;
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            hcnt_q <= '0;
            vcnt_q <= '0;
            rgb1_q <= '0;
            rgb2_q <= '0;
            rgb_q  <= '0;
            col_q  <= '0;
            row_q  <= '0;
            de_q   <= 1'b0;
        end else begin
            hcnt_q <= hcnt_d;
            vcnt_q <= vcnt_d;
            rgb1_q <= {R, G, B};
            rgb2_q <= rgb1_q;
            rgb_q  <= rgb_d;
            col_q  <= col_d;
            row_q  <= row_d;
            de_q   <= de_d;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge Reset) begin
        if (Reset) begin
            state_q      <= SEARCH;
            locked_q     <= 1'b0;
            sync_err_q   <= 1'b0;
            err_cnt_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            sync_err_q   <= 1'b0;
            frame_done_q <= v_edge && (state_q == LOCK);
            case (state_q)
                SEARCH: begin
                    if (v_edge) state_q <= ALIGN;
                end
                ALIGN: begin
                    // A bad frame length alone just restarts the measurement in ALIGN.
                    if (h_edge && !line_ok) begin
                        state_q <= SEARCH;
                    end else if (v_edge && frame_ok) begin
                        state_q  <= LOCK;
                        locked_q <= 1'b1;
                    end
                end
                LOCK: begin
                    if ((h_edge && !line_ok) || (v_edge && !frame_ok) || hcnt_sat) begin
                        state_q    <= SEARCH;
                        locked_q   <= 1'b0;
                        sync_err_q <= 1'b1;
                        if (err_cnt_q != 8'hFF) err_cnt_q <= err_cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q  <= SEARCH;
                    locked_q <= 1'b0;
                end
            endcase
        end
    end

    assign RX_COLUMN      = col_q;
    assign RX_ROW         = row_q;
    assign RX_DISP_ENABLE = de_q;
    assign RX_R           = rgb_q[2];
    assign RX_G           = rgb_q[1];
    assign RX_B           = rgb_q[0];
    assign LOCKED         = locked_q;
    assign SYNC_ERR       = sync_err_q;
    assign ERR_COUNT      = err_cnt_q;
    assign FRAME_DONE     = frame_done_q;

endmodule

// File: tb/tb_vga_sync_receiver.sv
// tb/tb_vga_sync_receiver.sv - directed bench for vga_sync_receiver on a scaled-down timing
module tb_vga_sync_receiver;

    localparam int H_VIS = 6, H_FP = 1, H_SW = 2, H_BP = 1;
    localparam int V_VIS = 8, V_FP = 1, V_SW = 1, V_BP = 1;
    localparam int H_TOTAL = 10, V_TOTAL = 11, H_START = 3, V_START = 2;

    logic        clk, rst, hs, vs, r, g, b;
    logic [10:0] col;
    logic [9:0]  row;
    logic        de, rx_r, rx_g, rx_b, locked, sync_err, frame_done;
    logic [7:0]  err_count;

    int n_run = 0, n_fail = 0;
    int n_fd = 0, n_serr = 0, n_de = 0, n_hit = 0, n_bad = 0;
    int fd0, se0, de0, hit0;

    vga_sync_receiver #(
        .H_VIS(H_VIS), .H_FP(H_FP), .H_SW(H_SW), .H_BP(H_BP),
        .V_VIS(V_VIS), .V_FP(V_FP), .V_SW(V_SW), .V_BP(V_BP),
        .SYNC_POL(1'b1)
    ) dut (
        .CLOCK_50(clk), .Reset(rst), .H_SYNC(hs), .V_SYNC(vs),
        .R(r), .G(g), .B(b),
        .RX_COLUMN(col), .RX_ROW(row), .RX_DISP_ENABLE(de),
        .RX_R(rx_r), .RX_G(rx_g), .RX_B(rx_b),
        .LOCKED(locked), .SYNC_ERR(sync_err), .ERR_COUNT(err_count),
        .FRAME_DONE(frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Only pixel (5,7) is lit at the source; anything else coloured or out of window is stray.
    always @(negedge clk) begin
        if (frame_done) n_fd++;
        if (sync_err) n_serr++;
        if (de) begin
            n_de++;
            if (col >= 11'(H_VIS) || row >= 10'(V_VIS)) n_bad++;
            if ({rx_r, rx_g, rx_b} != 3'b000) begin
                if ({rx_r, rx_g, rx_b} == 3'b111 && col == 11'd5 && row == 10'd7) n_hit++;
                else n_bad++;
            end
        end else if (col != 11'd0 || row != 10'd0 || {rx_r, rx_g, rx_b} != 3'b000) begin
            n_bad++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] outs();
        return {28'd0, col, row, de, rx_r, rx_g, rx_b, locked, sync_err, frame_done, err_count};
    endfunction

    task automatic drive(input logic h, input logic v, input logic lit);
        @(posedge clk);
        #1;
        hs = h; vs = v; r = lit; g = lit; b = lit;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0);
    endtask

    task automatic send_frame(input int n_lines, input int long_line, input int rst_line);
        int len;
        for (int v = 0; v < n_lines; v++) begin
            len = (v == long_line) ? H_TOTAL + 1 : H_TOTAL;
            for (int h = 0; h < len; h++) begin
                drive(h < H_SW, v < V_SW, (h == H_START + 5) && (v == V_START + 7));
                if (v == rst_line && h == 7) begin
                    rst = 1'b1;
                    #1;
                    check("reset_async_outs", outs(), 64'd0);
                end
                if (v == rst_line && h == 9) rst = 1'b0;
            end
        end
    endtask

    initial begin
        rst = 1'b1; hs = 1'b0; vs = 1'b0; r = 1'b0; g = 1'b0; b = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outs", outs(), 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(3);

        fd0 = n_fd; se0 = n_serr; de0 = n_de; hit0 = n_hit;
        send_frame(V_TOTAL, -1, -1);
        check("nom_locked_f1", locked, 0);
        send_frame(V_TOTAL, -1, -1);
        check("nom_locked_f2", locked, 1);
        for (int f = 0; f < 3; f++) send_frame(V_TOTAL, -1, -1);
        check("nom_frame_done", n_fd - fd0, 3);
        check("nom_sync_err", n_serr - se0, 0);
        check("nom_err_count", err_count, 0);
        check("nom_de_cycles", n_de - de0, 4 * H_VIS * V_VIS);
        check("nom_pixel_hits", n_hit - hit0, 4);

        se0 = n_serr;
        send_frame(V_TOTAL, 3, -1);
        check("long_sync_err", n_serr - se0, 1);
        check("long_err_count", err_count, 1);
        check("long_locked", locked, 0);
        send_frame(V_TOTAL, -1, -1);
        check("long_locked_g1", locked, 0);
        send_frame(V_TOTAL, -1, -1);
        check("long_locked_g2", locked, 1);

        se0 = n_serr;
        send_frame(V_TOTAL + 1, -1, -1);
        check("vlong_locked_pre", locked, 1);
        hit0 = n_hit;
        send_frame(V_TOTAL, -1, -1);
        check("vlong_locked_g1", locked, 0);
        check("vlong_sync_err", n_serr - se0, 1);
        check("vlong_err_count", err_count, 2);
        send_frame(V_TOTAL, -1, -1);
        check("vlong_locked_g2", locked, 0);
        send_frame(V_TOTAL, -1, -1);
        check("vlong_locked_g3", locked, 1);
        check("vlong_pixel_hits", n_hit - hit0, 1);

        se0 = n_serr;
        idle(1000);
        check("hold_locked_mid", locked, 1);
        idle(1100);
        check("hold_locked_end", locked, 0);
        check("hold_sync_err", n_serr - se0, 1);
        check("hold_err_count", err_count, 3);
        send_frame(V_TOTAL, -1, -1);
        send_frame(V_TOTAL, -1, -1);
        check("hold_relock", locked, 1);

        send_frame(V_TOTAL, -1, V_START + 4);
        check("rst_locked_after", locked, 0);
        check("rst_err_count", err_count, 0);
        send_frame(V_TOTAL, -1, -1);
        check("rst_locked_v1", locked, 0);
        send_frame(V_TOTAL, -1, -1);
        check("rst_locked_v2", locked, 1);

        se0 = n_serr;
        for (int i = 1; i <= 300; i++) begin
            send_frame(V_TOTAL, -1, -1);
            send_frame(2, 0, -1);
            if (i == 254) check("sat_err_254", err_count, 254);
            if (i == 255) check("sat_err_255", err_count, 255);
        end
        check("sat_err_300", err_count, 255);
        check("sat_sync_err_pulses", n_serr - se0, 300);
        check("sat_locked", locked, 0);
        check("stray_pixels", n_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
